// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: widths, ALU op codes, FSM state encoding
// and the operand bundle that is registered toward the ALU.
package alu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned NREQ   = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 4'b0000,
        OP_SUB = 4'b0001,
        OP_XOR = 4'b0010,
        OP_OR  = 4'b0011,
        OP_AND = 4'b0100,
        OP_SLL = 4'b0101,
        OP_SRL = 4'b0111,
        OP_ORI = 4'b1000,
        OP_LUI = 4'b1001,
        OP_SW  = 4'b1100,
        OP_LW  = 4'b1101
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_req_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the arbiter; slave is the arbiter's view,
// master the view of the requesters, response consumer and external ALU.
interface alu_arbiter_if;
    import alu_pkg::*;

    logic [NREQ-1:0]   req_valid_i;
    logic [NREQ-1:0]   req_ready_o;
    logic [OP_W-1:0]   req0_op_i;
    logic [OP_W-1:0]   req1_op_i;
    logic [DATA_W-1:0] req0_a_i;
    logic [DATA_W-1:0] req1_a_i;
    logic [DATA_W-1:0] req0_b_i;
    logic [DATA_W-1:0] req1_b_i;
    logic [OP_W-1:0]   alu_op_o;
    logic [DATA_W-1:0] alu_a_o;
    logic [DATA_W-1:0] alu_b_o;
    logic [DATA_W-1:0] alu_result_i;
    logic              alu_zero_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic              rsp_id_o;
    logic [DATA_W-1:0] rsp_result_o;
    logic              rsp_zero_o;
    logic              busy_o;

    modport master (
        output req_valid_i, req0_op_i, req1_op_i, req0_a_i, req1_a_i, req0_b_i, req1_b_i,
        output alu_result_i, alu_zero_i, rsp_ready_i,
        input  req_ready_o, alu_op_o, alu_a_o, alu_b_o,
        input  rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, busy_o
    );

    modport slave (
        input  req_valid_i, req0_op_i, req1_op_i, req0_a_i, req1_a_i, req0_b_i, req1_b_i,
        input  alu_result_i, alu_zero_i, rsp_ready_i,
        output req_ready_o, alu_op_o, alu_a_o, alu_b_o,
        output rsp_valid_o, rsp_id_o, rsp_result_o, rsp_zero_o, busy_o
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; on a tie the requester that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            if (req == 2'b11) begin
                gnt = last ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, one op at a time,
// round-robin on contention, with a held response carrying the requester id.
module alu_arbiter
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus
);

    state_e            state;
    state_e            state_next;
    alu_req_t          opnd_q;
    logic              id_q;
    logic              last_q;
    logic              rsp_valid_q;
    logic              rsp_zero_q;
    logic [DATA_W-1:0] rsp_result_q;
    logic [1:0]        gnt;
    logic              arb_en;
    logic              grant;
    logic              gnt_id;

    // A new request may be taken from IDLE, or from RESP in the cycle the response is consumed.
    assign arb_en = !reset && ((state == ST_IDLE) || ((state == ST_RESP) && bus.rsp_ready_i));
    assign grant  = |gnt;
    assign gnt_id = gnt[1];

    rr_arb2 u_arb (
        .req    (bus.req_valid_i),
        .last   (last_q),
        .enable (arb_en),
        .gnt    (gnt)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready_i) state_next = grant ? ST_EXEC : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand, pointer and response registers; ALU output is only sampled in EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opnd_q       <= '0;
            id_q         <= 1'b0;
            last_q       <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            if (grant) begin
                opnd_q <= gnt_id ? '{op: bus.req1_op_i, a: bus.req1_a_i, b: bus.req1_b_i}
                                 : '{op: bus.req0_op_i, a: bus.req0_a_i, b: bus.req0_b_i};
                id_q   <= gnt_id;
                last_q <= gnt_id;
            end
            if (state == ST_EXEC) begin
                rsp_valid_q  <= 1'b1;
                rsp_result_q <= bus.alu_result_i;
                rsp_zero_q   <= bus.alu_zero_i;
            end else if ((state == ST_RESP) && bus.rsp_ready_i) begin
                rsp_valid_q  <= 1'b0;
            end
        end
    end

    assign bus.req_ready_o  = gnt;
    assign bus.alu_op_o     = opnd_q.op;
    assign bus.alu_a_o      = opnd_q.a;
    assign bus.alu_b_o      = opnd_q.b;
    assign bus.rsp_valid_o  = rsp_valid_q;
    assign bus.rsp_id_o     = id_q;
    assign bus.rsp_result_o = rsp_result_q;
    assign bus.rsp_zero_o   = rsp_zero_q;
    assign bus.busy_o       = (state != ST_IDLE);

endmodule
